// File: rtl/add_sub_pipe.sv
// Elastic, pipelined add/subtract unit with overflow detection, optional
// saturation and STAGES valid/ready register stages (no bubbles, order kept).
module add_sub_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_sum,
  output logic             o_ovf
);

  localparam int unsigned RW   = WIDTH + 1;
  localparam int unsigned LAST = STAGES - 1;

  logic [RW-1:0]     a_ext;
  logic [RW-1:0]     b_ext;
  logic [RW-1:0]     raw;
  logic [RW-1:0]     res;
  logic              ovf;

  logic [STAGES-1:0] vld_q;
  logic [RW-1:0]     sum_q [STAGES];
  logic [STAGES-1:0] ovf_q;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              room;

  logic [STAGES-1:0] src_vld;
  logic [RW-1:0]     src_sum [STAGES];
  logic [STAGES-1:0] src_ovf;

  // Extend operands, add or subtract, flag overflow and clamp when asked
  always_comb begin
    a_ext = {(SIGNED ? i_a[WIDTH-1] : 1'b0), i_a};
    b_ext = {(SIGNED ? i_b[WIDTH-1] : 1'b0), i_b};
    raw   = i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    if (SIGNED) begin
      ovf = raw[WIDTH] ^ raw[WIDTH-1];
    end else begin
      // Unsigned: carry out on add, borrow (A<B) on sub both land in the top bit
      ovf = raw[WIDTH];
    end
    res = raw;
    if (i_sat && ovf) begin
      if (SIGNED) begin
        res = raw[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
      end else begin
        res = i_sub ? '0 : {1'b0, {WIDTH{1'b1}}};
      end
    end
  end

  // Advance/load enables resolved from the output end back to the input
  always_comb begin
    adv  = '0;
    load = '0;
    room = i_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k]  = vld_q[k] & room;
      load[k] = ~vld_q[k] | adv[k];
      room    = load[k];
    end
  end

  // Source of each stage: the arithmetic result for stage 0, the previous stage otherwise
  always_comb begin
    src_vld    = '0;
    src_ovf    = '0;
    src_vld[0] = i_valid;
    src_sum[0] = res;
    src_ovf[0] = ovf;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_vld[k] = vld_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_ovf[k] = ovf_q[k-1];
    end
  end

  // Stage registers; payload is only captured from a valid source so idle data never leaks out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            sum_q[k] <= src_sum[k];
            ovf_q[k] <= src_ovf[k];
          end
        end
      end
    end
  end

  assign o_ready = load[0];
  assign o_valid = vld_q[LAST];
  assign o_sum   = sum_q[LAST];
  assign o_ovf   = ovf_q[LAST];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: four instances (unsigned/signed, 1..3 stages),
// integer reference model with a FIFO scoreboard plus directed literal vectors.
module tb_add_sub_pipe;

  typedef logic [9:0] exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld  [4];
  logic       ordy [4];
  logic       sub  [4];
  logic       sat  [4];
  logic       ovld [4];
  logic       rdy  [4];
  logic       oovf [4];
  logic [7:0] a    [4];
  logic [7:0] b    [4];
  logic [8:0] osum [4];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   sel   = 0;
  int   n_out = 0;
  exp_t q[$];
  int   out_cyc[$];
  bit   stalled = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    add_sub_pipe #(
      .WIDTH (8),
      .STAGES((g == 2) ? 3 : ((g == 3) ? 1 : 2)),
      .SIGNED(g == 1 || g == 3)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_valid(vld[g]),
      .o_ready(ordy[g]),
      .i_a    (a[g]),
      .i_b    (b[g]),
      .i_sub  (sub[g]),
      .i_sat  (sat[g]),
      .o_valid(ovld[g]),
      .i_ready(rdy[g]),
      .o_sum  (osum[g]),
      .o_ovf  (oovf[g])
    );
  end

  function automatic int stg_of(input int k);
    return (k == 2) ? 3 : ((k == 3) ? 1 : 2);
  endfunction

  function automatic bit sgn_of(input int k);
    return (k == 1 || k == 3);
  endfunction

  // Reference: exact integer arithmetic, range test, clamp, then keep 9 bits
  function automatic exp_t model(input bit sgn, input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tsub, input logic tsat);
    int ia, ib, r;
    bit ov;
    if (sgn) begin
      ia = int'($signed(ta));
      ib = int'($signed(tb));
    end else begin
      ia = int'(ta);
      ib = int'(tb);
    end
    r  = tsub ? (ia - ib) : (ia + ib);
    ov = sgn ? (r > 127 || r < -128) : (r > 255 || r < 0);
    if (tsat && ov) begin
      if (sgn) r = (r > 0) ? 127 : -128;
      else     r = (r > 0) ? 255 : 0;
    end
    return {9'(r), ov};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard on the active instance: ready, ordering, values, stall hold
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      chk("ready", 32'(ordy[sel]), 32'((q.size() < stg_of(sel)) || rdy[sel]));
      if (stalled) chk("stall_hold_valid", 32'(ovld[sel]), 32'(1));
      if (ovld[sel]) begin
        if (q.size() == 0) chk("spurious_out", 32'(ovld[sel]), 32'(0));
        else               chk("result", 32'({osum[sel], oovf[sel]}), 32'(q[0]));
      end
      if (ovld[sel] && rdy[sel]) begin
        if (q.size() != 0) void'(q.pop_front());
        out_cyc.push_back(cyc);
        n_out++;
      end
      stalled = ovld[sel] && !rdy[sel];
      if (vld[sel] && ordy[sel])
        q.push_back(model(sgn_of(sel), a[sel], b[sel], sub[sel], sat[sel]));
    end
  end

  // Present one transaction and wait (bounded) until it is accepted
  task automatic put(input int k, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tsub, input logic tsat, output int acc_cyc);
    int n;
    n = 0;
    vld[k] = 1'b1; a[k] = ta; b[k] = tb; sub[k] = tsub; sat[k] = tsat;
    @(negedge clk);
    while (!ordy[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept", 32'(ordy[k]), 32'(1));
    acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic directed(input int k, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tsub, input logic tsat, input logic [8:0] esum,
                          input logic eovf, input string nm);
    int c0, n;
    sel = k;
    chk({"model_", nm}, 32'(model(sgn_of(k), ta, tb, tsub, tsat)), 32'({esum, eovf}));
    rdy[k] = 1'b1;
    put(k, ta, tb, tsub, tsat, c0);
    vld[k] = 1'b0;
    a[k] = 8'hA5; b[k] = 8'h5A;
    n = 0;
    @(negedge clk);
    while (!ovld[k] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({"latency_", nm}, 32'(ovld[k] ? (cyc - c0) : -1), 32'(stg_of(k)));
    chk({"value_", nm}, 32'({osum[k], oovf[k]}), 32'({esum, eovf}));
    @(posedge clk); #1;
  endtask

  task automatic stress(input int k, input int ncyc);
    sel = k;
    repeat (ncyc) begin
      vld[k] = ($urandom_range(0, 3) != 0);
      a[k]   = 8'($urandom);
      b[k]   = 8'($urandom);
      sub[k] = 1'($urandom);
      sat[k] = 1'($urandom);
      rdy[k] = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    vld[k] = 1'b0;
    rdy[k] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, first;
    int n0;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; rdy[k] = 1'b1; a[k] = '0; b[k] = '0; sub[k] = 1'b0; sat[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 4; k++) begin
      chk("rst_valid", 32'(ovld[k]), 32'(0));
      chk("rst_sum",   32'(osum[k]), 32'(0));
      chk("rst_ovf",   32'(oovf[k]), 32'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("post_rst_ready", 32'(ordy[k]), 32'(1));
    @(posedge clk); #1;

    // Unsigned, 2 stages
    directed(0, 8'd200, 8'd100, 1'b0, 1'b0, 9'd300,  1'b1, "u_add_ovf");
    directed(0, 8'd200, 8'd100, 1'b0, 1'b1, 9'd255,  1'b1, "u_add_sat");
    directed(0, 8'd10,  8'd20,  1'b1, 1'b0, 9'h1F6,  1'b1, "u_sub_borrow");
    directed(0, 8'd10,  8'd20,  1'b1, 1'b1, 9'd0,    1'b1, "u_sub_sat");
    directed(0, 8'd20,  8'd10,  1'b1, 1'b0, 9'd10,   1'b0, "u_sub_ok");
    // Signed, 2 stages
    directed(1, 8'd100, 8'd100, 1'b0, 1'b0, 9'h0C8,  1'b1, "s_add_ovf");
    directed(1, 8'd100, 8'd100, 1'b0, 1'b1, 9'h07F,  1'b1, "s_add_sat");
    directed(1, 8'h80,  8'd1,   1'b1, 1'b1, 9'h180,  1'b1, "s_sub_sat_min");
    directed(1, 8'hFB,  8'd3,   1'b0, 1'b0, 9'h1FE,  1'b0, "s_add_neg");
    // Signed, 1 stage; unsigned, 3 stages
    directed(3, 8'd127, 8'd1,   1'b0, 1'b0, 9'h080,  1'b1, "s1_add_ovf");
    directed(3, 8'h80,  8'd1,   1'b1, 1'b0, 9'h17F,  1'b1, "s1_sub_ovf");
    directed(2, 8'd255, 8'd255, 1'b0, 1'b1, 9'd255,  1'b1, "u3_add_sat");
    directed(2, 8'd0,   8'd0,   1'b1, 1'b0, 9'd0,    1'b0, "u3_zero");

    // Backpressure on the 2-stage unsigned unit
    sel = 0; rdy[0] = 1'b0; n0 = n_out;
    put(0, 8'd1,  8'd2,  1'b0, 1'b0, c);
    put(0, 8'd50, 8'd60, 1'b1, 1'b0, c);
    vld[0] = 1'b1; a[0] = 8'd7; b[0] = 8'd8; sub[0] = 1'b0; sat[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(ordy[0]), 32'(0));
      chk("bp_hold", 32'({ovld[0], osum[0], oovf[0]}), 32'({1'b1, 9'd3, 1'b0}));
    end
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    put(0, 8'd7, 8'd8, 1'b0, 1'b0, c);
    vld[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_out_count", 32'(n_out - n0), 32'(3));
    chk("bp_empty", 32'(q.size()), 32'(0));

    // Full throughput on the 3-stage unit
    sel = 2; rdy[2] = 1'b1; out_cyc.delete(); first = 0;
    for (int i = 0; i < 10; i++) begin
      put(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), c);
      if (i == 0) first = c;
      else chk("tp_no_stall", 32'(c - first), 32'(i));
    end
    vld[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("tp_count", 32'(out_cyc.size()), 32'(10));
    if (out_cyc.size() == 10) begin
      chk("tp_first_latency", 32'(out_cyc[0] - first), 32'(3));
      for (int i = 1; i < 10; i++) chk("tp_consecutive", 32'(out_cyc[i] - out_cyc[i-1]), 32'(1));
    end

    // Asynchronous reset with two transactions in flight
    sel = 1; rdy[1] = 1'b0;
    put(1, 8'd5, 8'd6, 1'b0, 1'b0, c);
    put(1, 8'd9, 8'd4, 1'b1, 1'b0, c);
    vld[1] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ovld[1]), 32'(0));
    chk("mid_rst_sum",   32'(osum[1]), 32'(0));
    chk("mid_rst_ovf",   32'(oovf[1]), 32'(0));
    rdy[1] = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(ordy[1]), 32'(1));
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_stale", 32'(ovld[1]), 32'(0));
    end
    @(posedge clk); #1;
    directed(1, 8'hFB, 8'd3, 1'b0, 1'b0, 9'h1FE, 1'b0, "after_rst");

    // Random traffic with random backpressure
    stress(3, 150);
    stress(2, 150);
    stress(0, 100);
    stress(1, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
